// File: rtl/stack_mem_ctrl.sv
// Downward-growing hardware stack: push1/push2/pop requests against an inferred
// word array with a registered read port, plus the stack pointer and overflow flag.
module stack_mem_ctrl #(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 16,
  parameter int SPW      = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [1:0]          req_op,
  input  logic [REG_BITS-1:0] wdata0,
  input  logic [REG_BITS-1:0] wdata1,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [REG_BITS-1:0] rsp_data,
  output logic                rsp_err,
  output logic [SPW-1:0]      sp_out,
  output logic                empty,
  output logic                full,
  output logic                ovf,
  input  logic                err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_EMPTY = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_TWO   = SPW'(2);

  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PUSH2 = 2'b10;
  localparam logic [1:0] OP_PUSH1 = 2'b11;

  typedef enum logic [1:0] {IDLE, PUSH2_B, POP_RSP} state_t;

  state_t              state, state_next;
  logic [SPW-1:0]      sp, sp_next;
  logic [REG_BITS-1:0] wdata1_hold;
  logic [REG_BITS-1:0] rd_word;
  logic                underflow;
  logic                rsp_zero;

  logic [REG_BITS-1:0] mem [DEPTH];

  logic                accept, op_pop, op_push1, op_push2;
  logic                push1_ok, push2_ok, pop_ok, push_rej;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [REG_BITS-1:0] mem_wdata;

  // Request decode; guards on sp keep the pointer from ever wrapping.
  assign accept   = req_valid && (state == IDLE);
  assign op_pop   = accept && (req_op == OP_POP);
  assign op_push1 = accept && (req_op == OP_PUSH1);
  assign op_push2 = accept && (req_op == OP_PUSH2);
  assign push1_ok = op_push1 && (sp != '0);
  assign push2_ok = op_push2 && (sp >= SP_TWO);
  assign pop_ok   = op_pop && (sp != SP_EMPTY);
  assign push_rej = (op_push1 && !push1_ok) || (op_push2 && !push2_ok);

  assign mem_we    = push1_ok || push2_ok || (state == PUSH2_B);
  assign mem_waddr = sp[AW-1:0] - AW'(1);
  assign mem_wdata = (state == PUSH2_B) ? wdata1_hold : wdata0;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sp          <= SP_EMPTY;
      wdata1_hold <= '0;
      underflow   <= 1'b0;
      rsp_zero    <= 1'b1;
      ovf         <= 1'b0;
    end else begin
      state <= state_next;
      sp    <= sp_next;
      if (push2_ok) begin
        wdata1_hold <= wdata1;
      end
      if (op_pop) begin
        underflow <= !pop_ok;
        rsp_zero  <= !pop_ok;
      end
      // A new rejection outranks a coincident clear.
      if (push_rej) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Storage: contents are never reset; read register only loads on a real pop.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (pop_ok) begin
      rd_word <= mem[sp[AW-1:0]];
    end
  end

  always_comb begin
    state_next = state;
    sp_next    = sp;
    case (state)
      IDLE: begin
        if (push1_ok) begin
          sp_next = sp - SPW'(1);
        end else if (push2_ok) begin
          sp_next    = sp - SPW'(1);
          state_next = PUSH2_B;
        end else if (op_pop) begin
          state_next = POP_RSP;
          if (pop_ok) begin
            sp_next = sp + SPW'(1);
          end
        end
      end
      PUSH2_B: begin
        sp_next    = sp - SPW'(1);
        state_next = IDLE;
      end
      POP_RSP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == POP_RSP);
    rsp_err   = (state == POP_RSP) && underflow;
    rsp_data  = rsp_zero ? '0 : rd_word;
    sp_out    = sp;
    empty     = (sp == SP_EMPTY);
    full      = (sp == '0);
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl at DEPTH = 4: push/pop ordering, overflow,
// underflow and asynchronous reset in the middle of multi-cycle operations.
module tb_stack_mem_ctrl;

  localparam int REG_BITS = 32;
  localparam int DEPTH    = 4;
  localparam int SPW      = $clog2(DEPTH) + 1;

  logic                clk;
  logic                rst_n;
  logic                req_valid;
  logic [1:0]          req_op;
  logic [REG_BITS-1:0] wdata0;
  logic [REG_BITS-1:0] wdata1;
  logic                req_ready;
  logic                rsp_valid;
  logic [REG_BITS-1:0] rsp_data;
  logic                rsp_err;
  logic [SPW-1:0]      sp_out;
  logic                empty;
  logic                full;
  logic                ovf;
  logic                err_clr;

  int n_checks = 0;
  int n_pass   = 0;

  stack_mem_ctrl #(.REG_BITS(REG_BITS), .DEPTH(DEPTH), .SPW(SPW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .wdata0(wdata0), .wdata1(wdata1), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sp_out(sp_out), .empty(empty), .full(full), .ovf(ovf), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request from a negedge; return at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] d0, input logic [31:0] d1);
    req_valid = 1'b1;
    req_op    = op;
    wdata0    = d0;
    wdata1    = d1;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'b00;
    $display("req op=%b d0=%h d1=%h -> sp=%0d ready=%b ovf=%b", op, d0, d1, sp_out, req_ready, ovf);
  endtask

  task automatic push1(input logic [31:0] d);
    issue(2'b11, d, 32'h0);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d, input logic [31:0] sp_exp);
    issue(2'b01, 32'h0, 32'h0);
    check({tag, "_valid"}, 32'(rsp_valid), 32'h1);
    check({tag, "_err"},   32'(rsp_err),   32'h0);
    check({tag, "_data"},  rsp_data,       d);
    check({tag, "_sp"},    32'(sp_out),    sp_exp);
    check({tag, "_ready"}, 32'(req_ready), 32'h0);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    wdata0    = '0;
    wdata1    = '0;
    err_clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_sp",    32'(sp_out),    32'd4);
    check("rst_empty", 32'(empty),     32'h1);
    check("rst_full",  32'(full),      32'h0);
    check("rst_ovf",   32'(ovf),       32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_err",   32'(rsp_err),   32'h0);
    check("rst_data",  rsp_data,       32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // push1 then pop
    push1(32'hA);
    check("p1_sp",    32'(sp_out),    32'd3);
    check("p1_empty", 32'(empty),     32'h0);
    check("p1_ready", 32'(req_ready), 32'h1);
    pop_expect("pop_a", 32'hA, 32'd4);
    check("pop_a_empty", 32'(empty),     32'h1);
    check("pop_a_after", 32'(rsp_valid), 32'h0);
    check("pop_a_hold",  rsp_data,       32'hA);

    // push2 then two pops
    issue(2'b10, 32'h11, 32'h22);
    check("p2_sp_b",    32'(sp_out),    32'd3);
    check("p2_ready_b", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("p2_sp",    32'(sp_out),    32'd2);
    check("p2_ready", 32'(req_ready), 32'h1);
    pop_expect("pop_22", 32'h22, 32'd3);
    pop_expect("pop_11", 32'h11, 32'd4);

    // fill, overflow, clear
    push1(32'h1);
    push1(32'h2);
    push1(32'h3);
    push1(32'h4);
    check("fill_sp",   32'(sp_out), 32'd0);
    check("fill_full", 32'(full),   32'h1);
    push1(32'h99);
    check("ovf1_sp",  32'(sp_out),    32'd0);
    check("ovf1_ovf", 32'(ovf),       32'h1);
    check("ovf1_rdy", 32'(req_ready), 32'h1);
    pulse_clr();
    check("clr_ovf", 32'(ovf), 32'h0);
    pop_expect("pop_4", 32'h4, 32'd1);

    // push2 at sp = 1 is rejected whole
    issue(2'b10, 32'h55, 32'h66);
    check("ovf2_sp",  32'(sp_out),    32'd1);
    check("ovf2_ovf", 32'(ovf),       32'h1);
    check("ovf2_rdy", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("ovf2_sp_hold", 32'(sp_out), 32'd1);
    pulse_clr();
    push1(32'h77);
    check("p1_at1_sp",  32'(sp_out), 32'd0);
    check("p1_at1_ovf", 32'(ovf),    32'h0);

    // overflow set outranks a coincident clear
    err_clr = 1'b1;
    push1(32'h88);
    err_clr = 1'b0;
    check("setwins_ovf", 32'(ovf), 32'h1);
    pulse_clr();
    check("setwins_clr", 32'(ovf), 32'h0);
    pop_expect("pop_77", 32'h77, 32'd1);
    pop_expect("pop_3",  32'h3,  32'd2);
    pop_expect("pop_2",  32'h2,  32'd3);
    pop_expect("pop_1",  32'h1,  32'd4);

    // underflow
    issue(2'b01, 32'h0, 32'h0);
    check("unf_valid", 32'(rsp_valid), 32'h1);
    check("unf_err",   32'(rsp_err),   32'h1);
    check("unf_data",  rsp_data,       32'h0);
    check("unf_sp",    32'(sp_out),    32'd4);
    @(negedge clk);
    check("unf_after_err", 32'(rsp_err), 32'h0);

    // reset during PUSH2_B takes effect without a clock edge
    issue(2'b10, 32'hAB, 32'hCD);
    check("rp2_sp_b", 32'(sp_out), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("rp2_sp",    32'(sp_out),    32'd4);
    check("rp2_ready", 32'(req_ready), 32'h1);
    check("rp2_empty", 32'(empty),     32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'h0, 32'h0);
    check("rp2_pop_err",  32'(rsp_err),   32'h1);
    check("rp2_pop_data", rsp_data,       32'h0);

    // reset during POP_RSP drops rsp_valid immediately
    check("rpop_valid_b", 32'(rsp_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rpop_valid", 32'(rsp_valid), 32'h0);
    check("rpop_err",   32'(rsp_err),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
